// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device-to-host receiver: FSM encoding and frame format.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int DATA_BITS  = 8;
  localparam bit ODD_PARITY = 1'b1;

  // Data byte plus its parity bit must carry an odd number of ones.
  function automatic logic parity_ok(input logic [DATA_BITS-1:0] data, input logic parity);
    return (^{data, parity}) == ODD_PARITY;
  endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Receiver result bus: scancode, strobes, busy flag and the four-code history for the display.
interface ps2_rx_if;

  logic [7:0]  code_out;
  logic        code_valid_out;
  logic        parity_err_out;
  logic        frame_err_out;
  logic        busy_out;
  logic [31:0] history_out;

  modport master (
    output code_out, code_valid_out, parity_err_out, frame_err_out, busy_out, history_out
  );

  modport slave (
    input code_out, code_valid_out, parity_err_out, frame_err_out, busy_out, history_out
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// Brings the raw PS/2 clock and data lines into clk_in and flags each ps2_clk falling edge.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic sync_data,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   prev_clk;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ps2_sync_edge: SYNC_STAGES must be at least 2");
  end

  // Flops reset to 1 so the idle-high lines never look like a fall coming out of reset.
  // sync_data is delayed one extra stage so it lines up with the registered fall pulse.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      clk_sync  <= '1;
      data_sync <= '1;
      prev_clk  <= 1'b1;
      sync_data <= 1'b1;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
      prev_clk  <= clk_sync[SYNC_STAGES-1];
      sync_data <= data_sync[SYNC_STAGES-1];
      fall      <= prev_clk & ~clk_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard frame receiver feeding the seven-segment display history.
// Optional frame watchdog enabled by defining PS2_TIMEOUT_EN.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic     clk_in,
  input  logic     rst_n_in,
  input  logic     ps2_clk_in,
  input  logic     ps2_data_in,
  ps2_rx_if.master bus
);

  ps2_state_t            state;
  logic [2:0]            bit_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  parity_bit;
  logic                  sync_data;
  logic                  fall;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 32768) begin : g_bad_timeout
    $error("ps2_rx: TIMEOUT_CYCLES must fit the 15-bit watchdog");
  end

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .sync_data  (sync_data),
    .fall       (fall)
  );

`ifdef PS2_TIMEOUT_EN
  localparam logic [14:0] WDOG_LAST = 15'(TIMEOUT_CYCLES - 1);

  logic [14:0] wdog;

  // Counts clk_in cycles since the last ps2_clk fall while a frame is open.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wdog <= '0;
    end else if (state == IDLE || fall) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + 15'd1;
    end
  end
`endif

  // Frame FSM; every output is registered here so strobes land one cycle after the stop-bit fall.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state              <= IDLE;
      bit_cnt            <= '0;
      shreg              <= '0;
      parity_bit         <= 1'b0;
      bus.code_out       <= '0;
      bus.code_valid_out <= 1'b0;
      bus.parity_err_out <= 1'b0;
      bus.frame_err_out  <= 1'b0;
      bus.busy_out       <= 1'b0;
      bus.history_out    <= '0;
    end else begin
      bus.code_valid_out <= 1'b0;
      bus.parity_err_out <= 1'b0;
      bus.frame_err_out  <= 1'b0;
      if (fall) begin
        case (state)
          IDLE: begin
            if (!sync_data) begin
              state        <= DATA;
              bit_cnt      <= '0;
              bus.busy_out <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {sync_data, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            parity_bit <= sync_data;
            state      <= STOP;
          end
          STOP: begin
            state        <= IDLE;
            bus.busy_out <= 1'b0;
            // A bad stop bit outranks a parity error.
            if (!sync_data) begin
              bus.frame_err_out <= 1'b1;
            end else if (!parity_ok(shreg, parity_bit)) begin
              bus.parity_err_out <= 1'b1;
            end else begin
              bus.code_out       <= shreg;
              bus.code_valid_out <= 1'b1;
              bus.history_out    <= {bus.history_out[23:0], shreg};
            end
          end
          default: begin
            state        <= IDLE;
            bus.busy_out <= 1'b0;
          end
        endcase
      end
`ifdef PS2_TIMEOUT_EN
      else if (state != IDLE && wdog == WDOG_LAST) begin
        state             <= IDLE;
        bus.busy_out      <= 1'b0;
        bus.frame_err_out <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: directed frames push expected strobes, a monitor pops and compares.
`timescale 1ns/1ps
module tb_ps2_rx;

  localparam int CLK_HALF_NS    = 5;
  localparam int PS2_HALF_NS    = 500;
  localparam int TIMEOUT_CYCLES = 20000;
  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_PERR  = 3'b010;
  localparam logic [2:0] K_FERR  = 3'b001;

  typedef struct packed {
    logic [2:0]  kind;
    logic [7:0]  code;
    logic [31:0] hist;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic ps2_clk_in;
  logic ps2_data_in;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  ps2_rx_if rx_bus();

  ps2_rx #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .bus        (rx_bus)
  );

  always #CLK_HALF_NS clk_in = ~clk_in;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    exp_t e;
    logic [2:0] obs;
    obs = {rx_bus.code_valid_out, rx_bus.parity_err_out, rx_bus.frame_err_out};
    if (obs != 3'b000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe: got strobes %b, expected none at %0t", obs, $time);
      end else begin
        e = exp_q.pop_front();
        check_output("strobe_kind", {29'd0, obs}, {29'd0, e.kind});
        check_output("strobe_code", {24'd0, rx_bus.code_out}, {24'd0, e.code});
        check_output("strobe_history", rx_bus.history_out, e.hist);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] global timeout");
  end

  task automatic expect_strobe(input logic [2:0] kind, input logic [7:0] code, input logic [31:0] hist);
    exp_q.push_back('{kind: kind, code: code, hist: hist});
  endtask

  task automatic send_bit(input logic b);
    #(PS2_HALF_NS/2) ps2_data_in = b;
    #(PS2_HALF_NS/2) ps2_clk_in  = 1'b0;
    #(PS2_HALF_NS)   ps2_clk_in  = 1'b1;
  endtask

  // Sends the first nbits of a frame (11 = complete), then idles the lines.
  task automatic apply_stimulus(input logic [7:0] data, input logic parity, input logic stop, input int nbits);
    logic [10:0] frame;
    frame = {stop, parity, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      send_bit(frame[i]);
      if (i == 1) check_output("busy_mid_frame", {31'd0, rx_bus.busy_out}, 32'd1);
    end
    ps2_data_in = 1'b1;
    #(PS2_HALF_NS*4);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk_in);
    check_output("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check_output({tag, "_code"}, {24'd0, rx_bus.code_out}, 32'd0);
    check_output({tag, "_history"}, rx_bus.history_out, 32'd0);
    check_output({tag, "_flags"},
                 {28'd0, rx_bus.code_valid_out, rx_bus.parity_err_out, rx_bus.frame_err_out, rx_bus.busy_out},
                 32'd0);
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    repeat (5) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (5) @(negedge clk_in);
  endtask

  initial begin
    ps2_clk_in  = 1'b1;
    ps2_data_in = 1'b1;
    do_reset();
    check_cleared("reset");

    // Single good frame.
    expect_strobe(K_VALID, 8'h1C, 32'h0000_001C);
    apply_stimulus(8'h1C, 1'b0, 1'b1, 11);
    wait_drain();
    check_output("s1_busy_after", {31'd0, rx_bus.busy_out}, 32'd0);
    check_output("s1_code", {24'd0, rx_bus.code_out}, 32'h1C);

    // Break/make sequence filling the history from a clean start.
    do_reset();
    check_output("s2_history_reset", rx_bus.history_out, 32'd0);
    expect_strobe(K_VALID, 8'h1C, 32'h0000_001C);
    apply_stimulus(8'h1C, 1'b0, 1'b1, 11);
    expect_strobe(K_VALID, 8'hF0, 32'h0000_1CF0);
    apply_stimulus(8'hF0, 1'b1, 1'b1, 11);
    expect_strobe(K_VALID, 8'h1C, 32'h001C_F01C);
    apply_stimulus(8'h1C, 1'b0, 1'b1, 11);
    wait_drain();
    check_output("s2_history_three", rx_bus.history_out, 32'h001C_F01C);
    expect_strobe(K_VALID, 8'h5A, 32'h1CF0_1C5A);
    apply_stimulus(8'h5A, 1'b1, 1'b1, 11);
    expect_strobe(K_VALID, 8'h29, 32'hF01C_5A29);
    apply_stimulus(8'h29, 1'b0, 1'b1, 11);
    wait_drain();
    check_output("s2_history_five", rx_bus.history_out, 32'hF01C_5A29);

    // Bad parity: error strobe only, code and history untouched.
    expect_strobe(K_PERR, 8'h29, 32'hF01C_5A29);
    apply_stimulus(8'h1C, 1'b1, 1'b1, 11);
    wait_drain();
    check_output("s3_code_held", {24'd0, rx_bus.code_out}, 32'h29);
    check_output("s3_history_held", rx_bus.history_out, 32'hF01C_5A29);

    // Bad stop bit, with a bad parity too: frame error wins; next frame still received.
    expect_strobe(K_FERR, 8'h29, 32'hF01C_5A29);
    apply_stimulus(8'h29, 1'b1, 1'b0, 11);
    wait_drain();
    check_output("s4_busy_after", {31'd0, rx_bus.busy_out}, 32'd0);
    expect_strobe(K_VALID, 8'h5A, 32'h1C5A_295A);
    apply_stimulus(8'h5A, 1'b1, 1'b1, 11);
    wait_drain();

`ifdef PS2_TIMEOUT_EN
    // Clock stalls after four data bits; the watchdog must abort only near TIMEOUT_CYCLES.
    expect_strobe(K_FERR, 8'h5A, 32'h1C5A_295A);
    apply_stimulus(8'h1C, 1'b0, 1'b1, 5);
    repeat (TIMEOUT_CYCLES - 1500) @(negedge clk_in);
    check_output("s5_busy_before_timeout", {31'd0, rx_bus.busy_out}, 32'd1);
    check_output("s5_no_early_strobe", exp_q.size(), 32'd1);
    repeat (6000) @(negedge clk_in);
    check_output("s5_busy_after_timeout", {31'd0, rx_bus.busy_out}, 32'd0);
    wait_drain();
    expect_strobe(K_VALID, 8'h29, 32'h5A29_5A29);
    apply_stimulus(8'h29, 1'b0, 1'b1, 11);
    wait_drain();
`endif

    // Reset in the middle of a frame, then a lone high pulse, then a clean frame.
    apply_stimulus(8'h1C, 1'b0, 1'b1, 7);
    rst_n_in = 1'b0;
    #1;
    check_cleared("s6_in_reset");
    repeat (5) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (5) @(negedge clk_in);
    send_bit(1'b1);
    #(PS2_HALF_NS*4);
    check_output("s6_spurious_busy", {31'd0, rx_bus.busy_out}, 32'd0);
    check_output("s6_spurious_history", rx_bus.history_out, 32'd0);
    expect_strobe(K_VALID, 8'h5A, 32'h0000_005A);
    apply_stimulus(8'h5A, 1'b1, 1'b1, 11);
    wait_drain();
    check_output("s6_code", {24'd0, rx_bus.code_out}, 32'h5A);

    repeat (20) @(negedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
